// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the two-FIFO arbiter pair (TX merge / RX split).
// Holds the FSM state type, the command length-code table and its decoder,
// and the default field layout of the command word used by both sides.
package fifo_arb_pkg;

  localparam int unsigned DW_DEF       = 32;
  localparam logic [31:0] SELMASK_DEF  = 32'h8000_0000;
  localparam int unsigned CNTSHIFT_DEF = 28;
  localparam logic [31:0] CNTMASK_DEF  = 32'h0000_0007;
  localparam int unsigned PCW_DEF      = 16;

  typedef enum logic {
    IDLE,
    PAYLOAD
  } state_t;

  // Length codes carried in the command word.
  localparam logic [2:0] LEN_0 = 3'd0;
  localparam logic [2:0] LEN_1 = 3'd1;
  localparam logic [2:0] LEN_2 = 3'd2;
  localparam logic [2:0] LEN_4 = 3'd3;
  localparam logic [2:0] LEN_8 = 3'd4;

  typedef struct packed {
    logic [3:0] cnt;    // payload words following the command
    logic       valid;  // code is one of the defined lengths
  } len_t;

  // Undefined codes decode to zero payload words with valid cleared.
  function automatic len_t len_decode(input logic [31:0] code);
    len_t r;
    r.cnt   = '0;
    r.valid = 1'b1;
    if (code[31:3] != '0) begin
      r.valid = 1'b0;
    end else begin
      case (code[2:0])
        LEN_0:   r.cnt = 4'd0;
        LEN_1:   r.cnt = 4'd1;
        LEN_2:   r.cnt = 4'd2;
        LEN_4:   r.cnt = 4'd4;
        LEN_8:   r.cnt = 4'd8;
        default: r.valid = 1'b0;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_arb_rx.sv
// Receive-side packet splitter. Pops a merged packet stream (command word
// plus 0/1/2/4/8 payload words) from an FWFT source FIFO and steers each
// whole packet to channel 1 or channel 2 according to the command select
// bit. Head-of-line blocking: a full target stalls the stream.
//
// Ports:
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   rd_data_i, empty_i   source FIFO head word / empty flag
//   rd_en_o              source pop (combinational)
//   f1_* / f2_*          destination write strobes, data, full flags
//   cnt_clr_i            synchronous clear of packet counters and err_o
//   pkt1_cnt_o/pkt2_cnt_o completed packets per channel (wrapping)
//   err_o                sticky undefined-length-code flag
//   busy_o               mid-packet indicator
module fifo_arb_rx
  import fifo_arb_pkg::*;
#(
  parameter int unsigned       DW       = DW_DEF,
  parameter logic [DW-1:0]     SELMASK  = DW'(SELMASK_DEF),
  parameter int unsigned       CNTSHIFT = CNTSHIFT_DEF,
  parameter logic [DW-1:0]     CNTMASK  = DW'(CNTMASK_DEF),
  parameter int unsigned       PCW      = PCW_DEF
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic [DW-1:0]  rd_data_i,
  input  logic           empty_i,
  output logic           rd_en_o,
  output logic           f1_wr_en_o,
  output logic [DW-1:0]  f1_wr_data_o,
  input  logic           f1_full_i,
  output logic           f2_wr_en_o,
  output logic [DW-1:0]  f2_wr_data_o,
  input  logic           f2_full_i,
  input  logic           cnt_clr_i,
  output logic [PCW-1:0] pkt1_cnt_o,
  output logic [PCW-1:0] pkt2_cnt_o,
  output logic           err_o,
  output logic           busy_o
);

  state_t         state_q, state_d;
  logic [3:0]     rem_q, rem_d;
  logic           sel_q, sel_d;
  logic [PCW-1:0] cnt1_q, cnt2_q;
  logic           err_q;

  logic [DW-1:0]  code_w;
  len_t           dec;
  logic           cmd_sel;
  logic           tgt_sel;
  logic           tgt_full;
  logic           xfer;
  logic           pkt_done;
  logic           err_set;

  assign cmd_sel  = |(rd_data_i & SELMASK);
  assign code_w   = (rd_data_i >> CNTSHIFT) & CNTMASK;
  assign dec      = len_decode(32'(code_w));
  assign tgt_sel  = (state_q == IDLE) ? cmd_sel : sel_q;
  assign tgt_full = tgt_sel ? f1_full_i : f2_full_i;
  // Gated by rstn_i so nothing moves while reset is held, even though the
  // state register already sits in IDLE.
  assign xfer     = rstn_i & ~empty_i & ~tgt_full;

  assign rd_en_o      = xfer;
  assign f1_wr_en_o   = xfer & tgt_sel;
  assign f2_wr_en_o   = xfer & ~tgt_sel;
  assign f1_wr_data_o = rd_data_i;
  assign f2_wr_data_o = rd_data_i;

  assign pkt1_cnt_o = cnt1_q;
  assign pkt2_cnt_o = cnt2_q;
  assign err_o      = err_q;
  assign busy_o     = (state_q == PAYLOAD);

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    sel_d    = sel_q;
    pkt_done = 1'b0;
    err_set  = 1'b0;
    if (xfer) begin
      case (state_q)
        IDLE: begin
          sel_d   = cmd_sel;
          err_set = ~dec.valid;
          if (dec.cnt != 4'd0) begin
            rem_d   = dec.cnt;
            state_d = PAYLOAD;
          end else begin
            pkt_done = 1'b1;
          end
        end
        PAYLOAD: begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            pkt_done = 1'b1;
            state_d  = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      err_q  <= 1'b0;
    end else if (cnt_clr_i) begin
      cnt1_q <= '0;
      cnt2_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (pkt_done && tgt_sel)  cnt1_q <= cnt1_q + PCW'(1);
      if (pkt_done && !tgt_sel) cnt2_q <= cnt2_q + PCW'(1);
      if (err_set)              err_q  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_arb_rx.sv
module tb_fifo_arb_rx;

  localparam int PCW = 4;

  logic           clk_i = 1'b0;
  logic           rstn_i;
  logic [31:0]    rd_data_i;
  logic           empty_i;
  logic           rd_en_o;
  logic           f1_wr_en_o;
  logic [31:0]    f1_wr_data_o;
  logic           f1_full_i;
  logic           f2_wr_en_o;
  logic [31:0]    f2_wr_data_o;
  logic           f2_full_i;
  logic           cnt_clr_i;
  logic [PCW-1:0] pkt1_cnt_o;
  logic [PCW-1:0] pkt2_cnt_o;
  logic           err_o;
  logic           busy_o;

  fifo_arb_rx #(.PCW(PCW)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .rd_data_i    (rd_data_i),
    .empty_i      (empty_i),
    .rd_en_o      (rd_en_o),
    .f1_wr_en_o   (f1_wr_en_o),
    .f1_wr_data_o (f1_wr_data_o),
    .f1_full_i    (f1_full_i),
    .f2_wr_en_o   (f2_wr_en_o),
    .f2_wr_data_o (f2_wr_data_o),
    .f2_full_i    (f2_full_i),
    .cnt_clr_i    (cnt_clr_i),
    .pkt1_cnt_o   (pkt1_cnt_o),
    .pkt2_cnt_o   (pkt2_cnt_o),
    .err_o        (err_o),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Source stream as produced by the TX side: every word tagged with its
  // packet's channel and its position in the packet.
  typedef struct {
    logic [31:0] w;
    bit          ch;
    bit          first;
    bit          last;
    bit          bad;
  } ent_t;

  ent_t src_q[$];
  int   lens[8] = '{0, 1, 2, 4, 8, 0, 0, 0};

  int checks   = 0;
  int failures = 0;
  int m_cnt1, m_cnt2;
  bit m_err, m_mid;
  int popped    = 0;
  int busy_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic add_pkt(input logic [31:0] cmd);
    ent_t e;
    int   n;
    n       = lens[cmd[30:28]];
    e.w     = cmd;
    e.ch    = cmd[31];
    e.first = 1'b1;
    e.last  = (n == 0);
    e.bad   = (cmd[30:28] >= 3'd5);
    src_q.push_back(e);
    for (int i = 0; i < n; i++) begin
      e.w     = $urandom;
      e.first = 1'b0;
      e.last  = (i == n - 1);
      e.bad   = 1'b0;
      src_q.push_back(e);
    end
  endtask

  // One cycle: drive inputs just after a falling edge, check the DUT outputs
  // against the model, advance the model by what must happen at the next
  // rising edge, then wait for the next falling edge.
  task automatic step(input bit stall, input bit f1f, input bit f2f, input bit clr);
    bit          has, tgt, ex;
    logic [31:0] w;
    has       = (src_q.size() != 0);
    w         = has ? src_q[0].w : $urandom;
    tgt       = has ? src_q[0].ch : 1'b0;
    empty_i   = stall || !has;
    rd_data_i = w;
    f1_full_i = f1f;
    f2_full_i = f2f;
    cnt_clr_i = clr;
    if (!rstn_i) begin
      m_mid = 0; m_cnt1 = 0; m_cnt2 = 0; m_err = 0;
    end
    #1;
    ex = rstn_i && !empty_i && !(tgt ? f1f : f2f);
    chk("rd_en", 32'(rd_en_o), 32'(ex));
    chk("f1_wr_en", 32'(f1_wr_en_o), 32'(ex && tgt));
    chk("f2_wr_en", 32'(f2_wr_en_o), 32'(ex && !tgt));
    if (ex) chk("wr_data", tgt ? f1_wr_data_o : f2_wr_data_o, w);
    chk("busy", 32'(busy_o), 32'(m_mid));
    chk("err", 32'(err_o), 32'(m_err));
    chk("pkt1_cnt", 32'(pkt1_cnt_o), 32'(m_cnt1 % (1 << PCW)));
    chk("pkt2_cnt", 32'(pkt2_cnt_o), 32'(m_cnt2 % (1 << PCW)));
    if (busy_o) busy_seen++;
    if (ex) begin
      if (rstn_i && !clr) begin
        if (src_q[0].first && src_q[0].bad) m_err = 1;
        if (src_q[0].last) begin
          if (src_q[0].ch) m_cnt1++;
          else             m_cnt2++;
        end
      end
      m_mid = !src_q[0].last;
      void'(src_q.pop_front());
      popped++;
    end
    if (rstn_i && clr) begin
      m_cnt1 = 0; m_cnt2 = 0; m_err = 0;
    end
    @(negedge clk_i);
  endtask

  initial begin
    int cyc;
    int start;
    ent_t e;
    rstn_i    = 1'b1;
    rd_data_i = '0;
    empty_i   = 1'b1;
    f1_full_i = 1'b0;
    f2_full_i = 1'b0;
    cnt_clr_i = 1'b0;
    #2 rstn_i = 1'b0;
    @(negedge clk_i);

    // Reset state
    repeat (3) step(0, 0, 0, 0);
    chk("reset_pkt1", 32'(pkt1_cnt_o), 0);
    chk("reset_busy", 32'(busy_o), 0);
    rstn_i = 1'b1;
    step(0, 0, 0, 0);

    // Single zero-length packet to channel 1
    add_pkt(32'h8000_0000);
    step(0, 0, 0, 0);
    chk("single_pkt1", 32'(pkt1_cnt_o), 1);
    chk("single_pkt2", 32'(pkt2_cnt_o), 0);

    // Length 8 to channel 2 with channel 1 held full
    add_pkt(32'h4000_0000);
    busy_seen = 0;
    repeat (9) step(0, 1, 0, 0);
    chk("len8_busy_cycles", 32'(busy_seen), 8);
    chk("len8_pkt2", 32'(pkt2_cnt_o), 1);
    chk("len8_src_drained", 32'(src_q.size()), 0);

    // Backpressure mid-packet
    add_pkt(32'h9000_0000);
    step(0, 0, 0, 0);
    repeat (5) step(0, 1, 0, 0);
    chk("bp_words_left", 32'(src_q.size()), 1);
    step(0, 0, 0, 0);
    chk("bp_pkt1", 32'(pkt1_cnt_o), 2);
    chk("bp_src_drained", 32'(src_q.size()), 0);

    // Undefined length code, sticky error, then clear
    add_pkt(32'h7000_0000);
    step(0, 0, 0, 0);
    chk("bad_err", 32'(err_o), 1);
    chk("bad_pkt2", 32'(pkt2_cnt_o), 2);
    repeat (3) step(0, 0, 0, 0);
    chk("bad_err_sticky", 32'(err_o), 1);
    step(0, 0, 0, 1);
    chk("clr_err", 32'(err_o), 0);
    chk("clr_pkt1", 32'(pkt1_cnt_o), 0);
    chk("clr_pkt2", 32'(pkt2_cnt_o), 0);

    // Reset mid-packet: abandon the rest, next head word is a command
    add_pkt(32'hB000_0000);
    repeat (3) step(0, 0, 0, 0);
    chk("mid_busy", 32'(busy_o), 1);
    src_q.delete();
    e.w = 32'h8000_0000; e.ch = 1'b1; e.first = 1'b1; e.last = 1'b1; e.bad = 1'b0;
    src_q.push_back(e);
    rstn_i = 1'b0;
    #1;
    chk("rst_async_busy", 32'(busy_o), 0);
    chk("rst_async_rd_en", 32'(rd_en_o), 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rstn_i = 1'b1;
    step(0, 0, 0, 0);
    chk("post_rst_pkt1", 32'(pkt1_cnt_o), 1);
    chk("post_rst_busy", 32'(busy_o), 0);

    // Randomized traffic
    start = popped;
    cyc   = 0;
    while ((popped - start) < 10000 && cyc < 60000) begin
      if (src_q.size() < 24) begin
        int code;
        code = ($urandom_range(0, 19) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4);
        add_pkt({1'($urandom_range(0, 1)), 3'(code), 28'($urandom)});
      end
      step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 3, $urandom_range(0, 1999) == 0);
      cyc++;
    end
    chk("rand_words_done", 32'((popped - start) >= 10000), 1);
    cyc = 0;
    while (src_q.size() != 0 && cyc < 1000) begin
      step(0, 0, 0, 0);
      cyc++;
    end
    chk("rand_drained", 32'(src_q.size()), 0);
    chk("final_busy", 32'(busy_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
